mem_port_arbiter: RTL and testbench

- Shares the single main-memory port among NUM_REQ compute-unit controllers, using round-robin arbitration.
- Each controller raises a level request and holds it for its whole burst. The grant stays with that owner until the owner drops its request.
- The block also muxes the granted controller's address and enables onto the memory port.
- Sits between the per-block controllers and the shared memory.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_picker.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encodings, default sizes
// and the one-hot to index helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANT   = 2'b01,
        S_RELEASE = 2'b10
    } state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_LOG_NUM_REQ = 2;
    localparam int DEF_MEM_ADDR_W  = 10;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic int unsigned onehot_to_index(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = idx | int'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after i_Last+1,
// found by rotating a doubled request vector and rotating the winner back.
module rr_priority_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int LOG_NUM_REQ = DEF_LOG_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]     i_Request,
    input  logic [LOG_NUM_REQ-1:0] i_Last,
    output logic                   o_Any,
    output logic [LOG_NUM_REQ-1:0] o_Winner_Index,
    output logic [NUM_REQ-1:0]     o_Winner_OneHot
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] rot_dbl;
    logic [2*NUM_REQ-1:0] back_dbl;
    logic [NUM_REQ-1:0]   rot_req;
    logic [NUM_REQ-1:0]   rot_onehot;
    logic                 found;
    logic [31:0]          start;

    // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
    always_comb begin
        start      = (32'(i_Last) + 32'd1) % 32'(NUM_REQ);
        req_dbl    = {i_Request, i_Request};
        rot_dbl    = req_dbl >> start;
        rot_req    = rot_dbl[NUM_REQ-1:0];
        rot_onehot = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rot_req[i] && !found) begin
                rot_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
        back_dbl        = {{NUM_REQ{1'b0}}, rot_onehot} << start;
        o_Winner_OneHot = back_dbl[NUM_REQ-1:0] | back_dbl[2*NUM_REQ-1:NUM_REQ];
    end

    assign o_Any          = |i_Request;
    assign o_Winner_Index = LOG_NUM_REQ'(onehot_to_index(32'(o_Winner_OneHot)));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner-holds arbiter for the shared memory port, with address/enable mux.
// Optional grant-length watchdog enabled by defining ARBITER_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int LOG_NUM_REQ = DEF_LOG_NUM_REQ,
    parameter int MEM_ADDR_W  = DEF_MEM_ADDR_W
`ifdef ARBITER_TIMEOUT_EN
    ,
    parameter int MAX_HOLD    = 64
`endif
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic [NUM_REQ-1:0]            i_Request,
    input  logic [NUM_REQ*MEM_ADDR_W-1:0] i_Mem_Address,
    input  logic [NUM_REQ-1:0]            i_Mem_Read_Enable,
    input  logic [NUM_REQ-1:0]            i_Mem_Write_Enable,
    output logic [NUM_REQ-1:0]            o_Grant,
    output logic [LOG_NUM_REQ-1:0]        o_Grant_Index,
    output logic                          o_Busy,
    output logic [MEM_ADDR_W-1:0]         o_Mem_Address,
    output logic                          o_Mem_Read_Enable,
    output logic                          o_Mem_Write_Enable
`ifdef ARBITER_TIMEOUT_EN
    ,
    output logic                          o_Timeout_Error
`endif
);

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [LOG_NUM_REQ-1:0] index_q, index_d;
    logic                   busy_q, busy_d;
    logic [LOG_NUM_REQ-1:0] last_q, last_d;

    logic                   pick_any;
    logic [LOG_NUM_REQ-1:0] pick_index;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic                   owner_req;
    logic                   release_now;

    rr_priority_picker #(
        .NUM_REQ     (NUM_REQ),
        .LOG_NUM_REQ (LOG_NUM_REQ)
    ) u_picker (
        .i_Request       (i_Request),
        .i_Last          (last_q),
        .o_Any           (pick_any),
        .o_Winner_Index  (pick_index),
        .o_Winner_OneHot (pick_onehot)
    );

    assign owner_req = i_Request[index_q];

`ifdef ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic              timeout_hit;

    // The grant lasts exactly MAX_HOLD cycles before a still-requesting owner is revoked.
    assign timeout_hit = (state_q == S_GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign release_now = !owner_req || timeout_hit;

    always_comb begin
        hold_d    = '0;
        timeout_d = timeout_q;
        if (state_q == S_GRANT && !release_now) hold_d = hold_q + HOLD_W'(1);
        if (timeout_hit && owner_req)           timeout_d = 1'b1;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_Timeout_Error = timeout_q;
`else
    assign release_now = !owner_req;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            index_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= LOG_NUM_REQ'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (pick_any) state_d = S_GRANT;
            S_GRANT:   if (release_now) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values of the registered grant outputs; no preemption while an owner holds.
    always_comb begin
        grant_d = grant_q;
        index_d = index_q;
        busy_d  = busy_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    index_d = pick_index;
                    busy_d  = 1'b1;
                    last_d  = pick_index;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_Mem_Address      = '0;
        o_Mem_Read_Enable  = 1'b0;
        o_Mem_Write_Enable = 1'b0;
        if (busy_q) begin
            o_Mem_Address      = i_Mem_Address[index_q*MEM_ADDR_W +: MEM_ADDR_W];
            o_Mem_Read_Enable  = i_Mem_Read_Enable[index_q];
            o_Mem_Write_Enable = i_Mem_Write_Enable[index_q];
        end
    end

    assign o_Grant       = grant_q;
    assign o_Grant_Index = index_q;
    assign o_Busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus reset, rotation and
// (with ARBITER_TIMEOUT_EN) watchdog sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] addr;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [3:0]  grant;
    logic [1:0]  gidx;
    logic        busy;
    logic [9:0]  maddr;
    logic        mrd;
    logic        mwr;
`ifdef ARBITER_TIMEOUT_EN
    logic        terr;
`endif

    int passed = 0;
    int total  = 0;

    mem_port_arbiter #(
        .NUM_REQ     (4),
        .LOG_NUM_REQ (2),
        .MEM_ADDR_W  (10)
`ifdef ARBITER_TIMEOUT_EN
        ,
        .MAX_HOLD    (8)
`endif
    ) dut (
        .i_Clock            (clk),
        .i_Reset            (rst),
        .i_Request          (req),
        .i_Mem_Address      (addr),
        .i_Mem_Read_Enable  (rd),
        .i_Mem_Write_Enable (wr),
        .o_Grant            (grant),
        .o_Grant_Index      (gidx),
        .o_Busy             (busy),
        .o_Mem_Address      (maddr),
        .o_Mem_Read_Enable  (mrd),
        .o_Mem_Write_Enable (mwr)
`ifdef ARBITER_TIMEOUT_EN
        ,
        .o_Timeout_Error    (terr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] rd;
        logic [3:0] wr;
        logic [3:0] e_grant;
        logic [1:0] e_idx;
        logic       e_busy;
        logic [9:0] e_addr;
        logic       e_rd;
        logic       e_wr;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " grant"}, 32'(grant), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " addr"}, 32'(maddr), 32'h0);
        check({tag, " rd"}, 32'(mrd), 32'h0);
        check({tag, " wr"}, 32'(mwr), 32'h0);
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        // Fixed per-requester addresses: r0=011, r1=155, r2=0AB, r3=2AA.
        addr = {10'h2AA, 10'h0AB, 10'h155, 10'h011};
        req  = '0;
        rd   = '0;
        wr   = '0;
        rst  = 1'b1;

        // Single request held 5 cycles then dropped.
        for (int i = 0; i < 5; i++) vecs[i] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 10'h0AB, 1'b1, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};
        // Mux: owner 1 reads, requester 3 writes but waits; then 3 owns, 0 waits (wrap 3->0).
        vecs[7]  = '{4'b0010, 4'b0010, 4'b1000, 4'b0010, 2'd1, 1'b1, 10'h155, 1'b1, 1'b0};
        vecs[8]  = '{4'b1010, 4'b0010, 4'b1000, 4'b0010, 2'd1, 1'b1, 10'h155, 1'b1, 1'b0};
        vecs[9]  = '{4'b1000, 4'b0010, 4'b1000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[10] = '{4'b1000, 4'b0010, 4'b1000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[11] = '{4'b1000, 4'b0010, 4'b1000, 4'b1000, 2'd3, 1'b1, 10'h2AA, 1'b0, 1'b1};
        vecs[12] = '{4'b1001, 4'b0010, 4'b1000, 4'b1000, 2'd3, 1'b1, 10'h2AA, 1'b0, 1'b1};
        vecs[13] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[14] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[15] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 2'd0, 1'b1, 10'h011, 1'b0, 1'b0};
        vecs[16] = '{4'b0000, 4'b0010, 4'b1000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0};

        step();
        step();
        check_idle("reset");
        check("reset idx", 32'(gidx), 32'h0);
`ifdef ARBITER_TIMEOUT_EN
        check("reset terr", 32'(terr), 32'h0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            req = vecs[i].req;
            rd  = vecs[i].rd;
            wr  = vecs[i].wr;
            step();
            check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            if (vecs[i].e_busy) check($sformatf("v%0d idx", i), 32'(gidx), 32'(vecs[i].e_idx));
            check($sformatf("v%0d addr", i), 32'(maddr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d rd", i), 32'(mrd), 32'(vecs[i].e_rd));
            check($sformatf("v%0d wr", i), 32'(mwr), 32'(vecs[i].e_wr));
        end

        // Reset mid-burst: owner 2 loses the grant without a clock edge.
        reset_pulse();
        req = 4'b0100;
        rd  = 4'b0100;
        wr  = 4'b0000;
        step();
        check("rstmid owner2", 32'(grant), 32'h4);
        req = 4'b0101;
        #3 rst = 1'b1;
        #1;
        check_idle("rstmid async");
        #2 rst = 1'b0;
        step();
        check("rstmid regrant", 32'(grant), 32'h1);
        check("rstmid regrant idx", 32'(gidx), 32'h0);

        // Rotation from reset with all four requesting: 0,1,2,3,0.
        reset_pulse();
        req = 4'b1111;
        rd  = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rot%0d grant", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            check($sformatf("rot%0d idx", k), 32'(gidx), 32'(k % 4));
            step();
            step();
            check($sformatf("rot%0d hold", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            req[k % 4] = 1'b0;
            step();
            check($sformatf("rot%0d release", k), 32'(busy), 32'h0);
            req = 4'b1111;
            step();
            check($sformatf("rot%0d turnaround", k), 32'(busy), 32'h0);
        end

`ifdef ARBITER_TIMEOUT_EN
        // Watchdog: owner 1 holds past 8 cycles, requester 2 takes over.
        reset_pulse();
        req = 4'b0010;
        step();
        check("to grant1", 32'(grant), 32'h2);
        req = 4'b0110;
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("to hold%0d", k), 32'(grant), 32'h2);
            check($sformatf("to terr%0d", k), 32'(terr), 32'h0);
        end
        step();
        check("to revoke busy", 32'(busy), 32'h0);
        check("to revoke terr", 32'(terr), 32'h1);
        step();
        check("to turnaround", 32'(busy), 32'h0);
        step();
        check("to grant2", 32'(grant), 32'h4);
        check("to sticky", 32'(terr), 32'h1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
